return_stack: RTL and testbench

//  Subroutine return-address stack for the double-bus 4-bit RISC core.
//  - On CALL, captures the 8-bit program counter value supplied by the sequencer.
//  - On RET, writes the saved address back onto the 4-bit data bus as two nibbles,

---
 rtl/return_stack.sv | 138 +++++++++++++
 tb/tb_return_stack.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// Subroutine return-address stack: saves the PC on CALL and replays it as two nibbles on RET.
// Optional RS_WRAP_EN: push while full overwrites the oldest entry instead of being dropped.
module return_stack #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 8,
    parameter int NIB_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    output logic [NIB_W-1:0]  bus_out,
    output logic              bus_drive,
    output logic              pc_load_hi,
    output logic              pc_load_lo,
    output logic              cy_ctl,
    output logic              ready,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

`ifdef RS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRV_HI, DRV_LO} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] out_reg;
    logic [PTR_W-1:0]  ptr_reg, ptr_next, top_ptr;
    logic [PTR_W:0]    count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;
    logic              idle, do_pop, do_push, ovf_evt, udf_evt;

    // ptr_reg is the next free slot; the top entry sits one below it
    assign top_ptr = ptr_reg - PTR_W'(1);
    assign idle    = (state_reg == IDLE);
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign do_pop  = idle && pop && !empty;
    assign udf_evt = idle && pop && empty;
    assign ovf_evt = idle && push && !pop && full;
    assign do_push = idle && push && !pop && (!full || WRAP);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (do_pop) state_next = DRV_HI;
            DRV_HI:  state_next = DRV_LO;
            DRV_LO:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode, purely from registered state
    always_comb begin
        bus_out    = '0;
        bus_drive  = 1'b0;
        pc_load_hi = 1'b0;
        pc_load_lo = 1'b0;
        ready      = 1'b0;
        case (state_reg)
            IDLE:   ready = 1'b1;
            DRV_HI: begin
                bus_out    = out_reg[ADDR_W-1:NIB_W];
                bus_drive  = 1'b1;
                pc_load_hi = 1'b1;
            end
            DRV_LO: begin
                bus_out    = out_reg[NIB_W-1:0];
                bus_drive  = 1'b1;
                pc_load_lo = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    assign cy_ctl = 1'b0;

    // Pointer, occupancy and sticky flags; a new error event beats clr_err
    always_comb begin
        ptr_next       = ptr_reg;
        count_next     = count_reg;
        overflow_next  = (overflow_reg && !clr_err) || ovf_evt;
        underflow_next = (underflow_reg && !clr_err) || udf_evt;
        if (do_pop) begin
            ptr_next   = top_ptr;
            count_next = count_reg - (PTR_W+1)'(1);
        end else if (do_push) begin
            ptr_next = ptr_reg + PTR_W'(1);
            if (!full) count_next = count_reg + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            ptr_reg       <= ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage with registered read; contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (do_push) mem[ptr_reg] <= pc_in;
        if (do_pop)  out_reg      <= mem[top_ptr];
    end

    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: stimulus queues expected bus nibbles, a monitor checks them.
module tb_return_stack;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pc_in = '0;
    logic       push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic [3:0] bus_out;
    logic       bus_drive, pc_load_hi, pc_load_lo, cy_ctl, ready;
    logic [2:0] count;
    logic       empty, full, overflow, underflow;

    typedef struct packed {
        logic [3:0] nib;
        logic       hi;
        logic       lo;
    } drv_t;

    drv_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    return_stack dut (
        .clock(clock), .reset(reset), .pc_in(pc_in), .push(push), .pop(pop),
        .clr_err(clr_err), .bus_out(bus_out), .bus_drive(bus_drive),
        .pc_load_hi(pc_load_hi), .pc_load_lo(pc_load_lo), .cy_ctl(cy_ctl),
        .ready(ready), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_push(input logic [7:0] v);
        push = 1'b1; pc_in = v;
        tick();
        push = 1'b0;
    endtask

    // Pop and expect the full two-nibble replay of addr
    task automatic do_pop(input logic [7:0] addr);
        exp_q.push_back('{nib: addr[7:4], hi: 1'b1, lo: 1'b0});
        exp_q.push_back('{nib: addr[3:0], hi: 1'b0, lo: 1'b1});
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("ready_low_in_drv_hi", ready, 0);
        tick();
        tick();
        chk("ready_back_idle", ready, 1);
        chk("bus_out_idle", bus_out, 0);
    endtask

    // Monitor: every cycle the DUT drives the bus must match the next queued nibble
    initial begin
        drv_t e;
        forever begin
            @(negedge clock);
            if (bus_drive || pc_load_hi || pc_load_lo) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_drive: got drive=%0b hi=%0b lo=%0b nib=%0h, expected no drive",
                             bus_drive, pc_load_hi, pc_load_lo, bus_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus_drive, bus_out, pc_load_hi, pc_load_lo, cy_ctl} !==
                        {1'b1, e.nib, e.hi, e.lo, 1'b0}) begin
                        miscompares++;
                        $display("FAIL bus_nibble: got nib=%0h drive=%0b hi=%0b lo=%0b cy=%0b, expected nib=%0h drive=1 hi=%0b lo=%0b cy=0",
                                 bus_out, bus_drive, pc_load_hi, pc_load_lo, cy_ctl, e.nib, e.hi, e.lo);
                    end else begin
                        $display("ok   bus_nibble nib=%0h hi=%0b lo=%0b", bus_out, pc_load_hi, pc_load_lo);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Reset state
        tick(); tick();
        reset = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", ready, 1);
        chk("rst_drive_strobes", {bus_drive, pc_load_hi, pc_load_lo, cy_ctl}, 0);
        chk("rst_flags", {overflow, underflow}, 0);

        // 2. Two pushes, two pops, high nibble first
        do_push(8'h3A);
        do_push(8'hC5);
        chk("count_two", count, 2);
        do_pop(8'hC5);
        chk("count_one", count, 1);
        do_pop(8'h3A);
        chk("empty_after_pops", empty, 1);

        // 3. Underflow and clear
        pop = 1'b1; tick(); pop = 1'b0;
        chk("underflow_set", underflow, 1);
        chk("underflow_count", count, 0);
        chk("underflow_ready", ready, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("underflow_cleared", underflow, 0);

        // New error event in the same cycle as clr_err wins
        pop = 1'b1; clr_err = 1'b1; tick(); pop = 1'b0; clr_err = 1'b0;
        chk("event_beats_clr", underflow, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_again", underflow, 0);

        // 4. Overflow at DEPTH=4
        do_push(8'h11); do_push(8'h22); do_push(8'h33); do_push(8'h44);
        chk("full_set", full, 1);
        do_push(8'h55);
        chk("overflow_set", overflow, 1);
        chk("overflow_count", count, 4);
`ifdef RS_WRAP_EN
        do_pop(8'h55); do_pop(8'h44); do_pop(8'h33); do_pop(8'h22);
`else
        do_pop(8'h44); do_pop(8'h33); do_pop(8'h22); do_pop(8'h11);
`endif
        chk("empty_after_four", empty, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("overflow_cleared", overflow, 0);

        // push/pop while not ready are ignored
        do_push(8'h12);
        do_push(8'h34);
        exp_q.push_back('{nib: 4'h3, hi: 1'b1, lo: 1'b0});
        exp_q.push_back('{nib: 4'h4, hi: 1'b0, lo: 1'b1});
        pop = 1'b1; tick();
        push = 1'b1; pc_in = 8'hFF; tick();
        push = 1'b0; pop = 1'b0; tick();
        chk("busy_ignored_count", count, 1);
        chk("busy_no_flags", {overflow, underflow}, 0);
        do_pop(8'h12);

        // 5. Simultaneous push and pop: pop wins, push dropped
        do_push(8'h7E);
        chk("count_one_7e", count, 1);
        exp_q.push_back('{nib: 4'h7, hi: 1'b1, lo: 1'b0});
        exp_q.push_back('{nib: 4'hE, hi: 1'b0, lo: 1'b1});
        push = 1'b1; pop = 1'b1; pc_in = 8'h90; tick();
        push = 1'b0; pop = 1'b0;
        tick(); tick();
        chk("pushpop_count", count, 0);
        chk("pushpop_flags", {overflow, underflow}, 0);

        // 6. Reset during DRV_HI aborts the low-nibble strobe
        do_push(8'hAB);
        exp_q.push_back('{nib: 4'hA, hi: 1'b1, lo: 1'b0});
        pop = 1'b1; tick(); pop = 1'b0;
        reset = 1'b0; tick();
        chk("midrst_drive", {bus_drive, pc_load_hi, pc_load_lo}, 0);
        chk("midrst_count", count, 0);
        chk("midrst_ready", ready, 1);
        reset = 1'b1;
        tick(); tick(); tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
